// File: rtl/mem_arbiter.sv
// Two-port arbiter: instruction fetch and load/store share one single-port word memory.
// Data port wins by default; a starvation counter forces fetch through after STARVE_LIMIT denials.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_we,
  input  logic [31:0] mem_data_out
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] starve_cnt;
  logic             force_i;

  always_comb begin
    force_i = i_req & (starve_cnt >= LIMIT);
    d_gnt   = d_req & ~force_i;
    i_gnt   = i_req & ~d_gnt;
  end

  // Idle cycles present the fetch address so the memory only performs a harmless read.
  assign mem_address = d_gnt ? d_addr : i_addr;
  assign mem_data_in = d_wdata;
  assign mem_we      = d_gnt & d_we & resetn;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
    end else begin
      i_rvalid <= i_gnt;
      if (i_gnt) begin
        i_rdata <= mem_data_out;
      end
    end
  end

  // Stores acknowledge through d_rvalid but leave the last load data in place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= d_gnt;
      if (d_gnt && !d_we) begin
        d_rdata <= mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory, a reference memory
// image and per-port response queues checked whenever rvalid is observed.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_address, mem_data_in, mem_data_out;

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  logic        mem_loaded = 1'b0;

  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] d_exp;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_gnt        (i_gnt),
    .i_rvalid     (i_rvalid),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_address[13:2]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h1000_0000 + i;
      mem[4]     <= 32'hDEAD_BEEF;
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_address[13:2]] <= mem_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Every negedge out of reset: rvalid must match whether a response is owed.
  always @(negedge clk) begin
    if (resetn) begin
      check("i_rvalid", {31'b0, i_rvalid}, {31'b0, iq.size() != 0});
      if (i_rvalid && iq.size() != 0) check("i_rdata", i_rdata, iq.pop_front());
      check("d_rvalid", {31'b0, d_rvalid}, {31'b0, dq.size() != 0});
      if (d_rvalid && dq.size() != 0) check("d_rdata", d_rdata, dq.pop_front());
    end
  end

  // Called just after a posedge; drives one cycle and checks the expected grant.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd,
                      input logic eig, input logic edg);
    logic [31:0] ie, de;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    check("i_gnt", {31'b0, i_gnt}, {31'b0, eig});
    check("d_gnt", {31'b0, d_gnt}, {31'b0, edg});
    check("mem_we", {31'b0, mem_we}, {31'b0, edg & dw});
    check("mem_address", mem_address, edg ? da : ia);
    ie = ref_mem[ia[13:2]];
    de = (edg && !dw) ? ref_mem[da[13:2]] : d_exp;
    @(posedge clk);
    if (eig) iq.push_back(ie);
    if (edg) begin
      dq.push_back(de);
      d_exp = de;
      if (dw) ref_mem[da[13:2]] = dwd;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int nd;
    logic ig;
    logic [31:0] da;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h1000_0000 + i;
    ref_mem[4] = 32'hDEAD_BEEF;
    d_exp  = 32'h0;
    resetn = 1'b0;
    i_req = 1'b0; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_d_gnt", {31'b0, d_gnt}, 32'h1);
    check("rst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    check("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // 1: first fetch after reset
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // 2: store then load of the same word on back-to-back cycles
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
    idle();

    // 3: both ports saturated, fetch forced through every fifth cycle
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      ig = (k % 5) == 4;
      da = 32'h300 + 32'(nd) * 4;
      step(1'b1, 32'h40 + 32'(k / 5) * 4, 1'b1, nd[0], da, 32'hC0DE_0000 + 32'(nd), ig, !ig);
      if (!ig) nd++;
    end
    idle();

    // 4: simultaneous single requests, data first then the held fetch
    step(1'b1, 32'h30, 1'b1, 1'b0, 32'h34, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // 5: build the counter to its limit, then reset with a response in flight
    for (int k = 0; k < 4; k++) step(1'b1, 32'h60, 1'b1, 1'b0, 32'h70 + 32'(k) * 4, 32'h0, 1'b0, 1'b1);
    resetn = 1'b0;
    #1;
    check("rst_async_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    check("rst_async_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    iq.delete();
    dq.delete();
    d_exp = 32'h0;
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_d_rdata", d_rdata, 32'h0);
    check("post_rst_i_rdata", i_rdata, 32'h0);
    step(1'b1, 32'h60, 1'b1, 1'b0, 32'h74, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // 6: store above 16 KB wraps onto word 4; high and low address bits pass through
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h4010, 32'hA5A5_A5A5, 1'b0, 1'b1);
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h1234_0013, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();
    idle();

    check("i_queue_drained", 32'(iq.size()), 32'h0);
    check("d_queue_drained", 32'(dq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    n_err++;
    $display("FAIL timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
